mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Memory access sequencer directly downstream of the control-unit FSM.
- Accepts single-word read/write requests (address, write data) and drives the external asynchronous SRAM with registered, glitch-free strobes and a configurable number of wait states.
- Decodes one memory-mapped I/O word: reads return the switches, writes load the hex-display register.
- Returns read data with a one-cycle Done pulse, so the control FSM needs only one wait state per memory phase.

Parameters:
- WAIT_STATES, 2, cycles OE_n/WE_n stay low per SRAM access (legal range 1..15).
- IO_ADDR, 16'hFFFF, CPU address mapped to switches (read) and hex register (write).
- SRAM_AW, 20, external SRAM address width; the CPU address is zero-extended to it.

Ports:
- Clk  in  1  system clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Req_rd  in  1  read request, sampled only in IDLE
- Req_wr  in  1  write request, sampled only in IDLE
- Addr  in  16  CPU word address
- Wdata  in  16  write data
- Rdata  out  16  registered read data, valid while Done=1 and held until the next read completes
- Done  out  1  one-cycle completion pulse
- Busy  out  1  high in every state except IDLE
- Err  out  1  one-cycle pulse when Req_rd and Req_wr are both high in IDLE
- Switches  in  16  board switches (asynchronous; double-flop synchronised internally)
- Hex_out  out  16  hex-display register
- Sram_addr  out  SRAM_AW  SRAM address
- Sram_dq  inout  16  SRAM data bus; driven only in WR_SETUP, WR and WR_HOLD, otherwise Z
- Sram_ce_n, Sram_oe_n, Sram_we_n, Sram_ub_n, Sram_lb_n  out  1 each  active-low SRAM strobes

Behaviour:
- Reset (async, Reset_n=0):
  - state=IDLE; Rdata=0, Hex_out=0, Done=0, Err=0, Busy=0, Sram_addr=0.
  - Sram_oe_n=1, Sram_we_n=1, Sram_ce_n=1, Sram_ub_n=1, Sram_lb_n=1; Sram_dq=Z.
  - Reset mid-access aborts the access immediately with no Done; a write in flight leaves that SRAM word undefined.
- Outside reset: CE_n/UB_n/LB_n are 0. OE_n and WE_n are registered outputs and are never both 0.
- IDLE:
  - On a clock edge with exactly one request high, latch Addr/Wdata and set the wait counter to WAIT_STATES.
  - Addr==IO_ADDR with a read: Rdata<=synchronised Switches, go to DONE.
  - Addr==IO_ADDR with a write: Hex_out<=Wdata, go to DONE. SRAM is never touched for IO_ADDR.
  - Other addresses: read goes to RD; write goes to WR_SETUP.
  - Both requests high: Err pulses the next cycle, stay IDLE, no access.
  - No request: stay IDLE.
- RD: OE_n=0 for WAIT_STATES cycles. On the edge ending the last RD cycle, Rdata<=Sram_dq; go to DONE.
- WR_SETUP: 1 cycle; address and data driven, WE_n=1.
- WR: WE_n=0 for WAIT_STATES cycles, data driven.
- WR_HOLD: 1 cycle; WE_n=1, data still driven (hold time); go to DONE.
- DONE: Done=1 for exactly one cycle, then IDLE.
- Latency from the request-sampling edge at cycle t:
  - SRAM read: Done in cycle t+WAIT_STATES+1.
  - SRAM write: Done in cycle t+WAIT_STATES+3.
  - IO read/write: Done in cycle t+1.
- Requests arriving while Busy=1, including during DONE, are ignored (not queued). The requester must hold the request until Done.
- Rdata is unchanged by writes, errors and ignored requests.
- Sram_addr = {zeros, latched Addr}, held constant for the whole access.

Decomposition:
- Package mem_ctrl_pkg:
  - state enum {IDLE, RD, WR_SETUP, WR, WR_HOLD, DONE}
  - IO_ADDR default constant
  - strobe level constants (ASSERT_N=0, DEASSERT_N=1)
  - wait-counter width (4 bits)
- One sub-module, mem_io_map: switch double-flop synchroniser, IO address decode and the Hex_out register.
- The FSM, wait counter and SRAM drive stay in mem_access_ctrl.

Test Plan:
- Reset mid-write: assert Reset_n=0 during WR -> strobes go inactive in the same cycle without a clock edge, Sram_dq=Z, Done never pulses, Hex_out=0.
- SRAM read, WAIT_STATES=2: SRAM model holds 16'hBEEF at 0x0123; Req_rd, Addr=0x0123 -> OE_n low exactly 2 cycles, Done at t+3, Rdata=16'hBEEF, WE_n stays 1 throughout.
- SRAM write: Req_wr, Addr=0x0040, Wdata=16'h1234 -> WE_n low exactly 2 cycles bracketed by setup and hold cycles with data driven, Done at t+5; a read-back of 0x0040 returns 16'h1234.
- IO access: Switches=16'h00A5 held 3 cycles, read Addr=16'hFFFF -> Done at t+1, Rdata=16'h00A5, no SRAM strobes; write 16'hC0DE to 16'hFFFF -> Hex_out=16'hC0DE, SRAM untouched.
- Conflicts: Req_rd=Req_wr=1 in IDLE -> Err pulse one cycle, no strobes, Rdata unchanged; a new Req_rd during an active write -> ignored, exactly one Done.
- Parameter sweep WAIT_STATES=1 and 15 -> OE_n/WE_n low width equals WAIT_STATES, and latencies match the formulas above.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the SRAM access sequencer.
// Strobe constants name the active-low levels so the drive logic reads as intent.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    WR_SETUP = 3'd2,
    WR       = 3'd3,
    WR_HOLD  = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic [15:0] IO_ADDR_DEF = 16'hFFFF;
  localparam logic        ASSERT_N    = 1'b0;
  localparam logic        DEASSERT_N  = 1'b1;
  localparam int          WAIT_CW     = 4;

endpackage

// File: rtl/mem_io_map.sv
// Memory-mapped I/O word: switch synchroniser, IO address decode and hex-display register.
// The switches are asynchronous to Clk and pass through two flops before use.
module mem_io_map
  import mem_ctrl_pkg::*;
#(
  parameter logic [15:0] IO_ADDR = IO_ADDR_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_switches,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_wdata,
  input  logic        i_hex_we,
  output logic        o_is_io,
  output logic [15:0] o_switches_sync,
  output logic [15:0] o_hex
);

  logic [15:0] r_sw_meta;
  logic [15:0] r_sw_sync;
  logic [15:0] r_hex;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
      r_hex     <= '0;
    end else begin
      r_sw_meta <= i_switches;
      r_sw_sync <= r_sw_meta;
      if (i_hex_we) r_hex <= i_wdata;
    end
  end

  assign o_is_io         = (i_addr == IO_ADDR);
  assign o_switches_sync = r_sw_sync;
  assign o_hex           = r_hex;

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-word SRAM access sequencer with registered strobes, programmable wait states
// and one memory-mapped I/O word. Dbg_state exposes the FSM state for observation.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int          WAIT_STATES = 2,
  parameter logic [15:0] IO_ADDR     = IO_ADDR_DEF,
  parameter int          SRAM_AW     = 20
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Req_rd,
  input  logic               Req_wr,
  input  logic [15:0]        Addr,
  input  logic [15:0]        Wdata,
  output logic [15:0]        Rdata,
  output logic               Done,
  output logic               Busy,
  output logic               Err,
  input  logic [15:0]        Switches,
  output logic [15:0]        Hex_out,
  output logic [SRAM_AW-1:0] Sram_addr,
  inout  wire  [15:0]        Sram_dq,
  output logic               Sram_ce_n,
  output logic               Sram_oe_n,
  output logic               Sram_we_n,
  output logic               Sram_ub_n,
  output logic               Sram_lb_n,
  output state_t             Dbg_state
);

  localparam logic [WAIT_CW-1:0] WS = WAIT_CW'(WAIT_STATES);

  state_t               r_state;
  state_t               w_next;
  logic [WAIT_CW-1:0]   r_wait;
  logic [SRAM_AW-1:0]   r_addr;
  logic [15:0]          r_wdata;
  logic [15:0]          r_rdata;
  logic                 r_oe_n;
  logic                 r_we_n;
  logic                 r_en_n;
  logic                 r_dq_oe;
  logic                 r_err;
  logic                 w_req_one;
  logic                 w_conflict;
  logic                 w_accept;
  logic                 w_last_wait;
  logic                 w_is_io;
  logic                 w_hex_we;
  logic                 w_oe_n_nxt;
  logic                 w_we_n_nxt;
  logic                 w_dq_oe_nxt;
  logic [15:0]          w_sw_sync;

  // Handshake: a request is taken only in IDLE with exactly one of Req_rd/Req_wr high;
  // the requester holds it until the one-cycle Done, and anything seen while Busy is dropped.
  assign w_req_one   = Req_rd ^ Req_wr;
  assign w_conflict  = Req_rd & Req_wr;
  assign w_accept    = (r_state == IDLE) && w_req_one;
  assign w_last_wait = (r_wait == WAIT_CW'(1));
  assign w_hex_we    = w_accept && Req_wr && w_is_io;

  mem_io_map #(.IO_ADDR(IO_ADDR)) u_io_map (
    .i_clk          (Clk),
    .i_rst_n        (Reset_n),
    .i_switches     (Switches),
    .i_addr         (Addr),
    .i_wdata        (Wdata),
    .i_hex_we       (w_hex_we),
    .o_is_io        (w_is_io),
    .o_switches_sync(w_sw_sync),
    .o_hex          (Hex_out)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_req_one) begin
          if (w_is_io)     w_next = DONE;
          else if (Req_rd) w_next = RD;
          else             w_next = WR_SETUP;
        end
      end
      RD:       if (w_last_wait) w_next = DONE;
      WR_SETUP: w_next = WR;
      WR:       if (w_last_wait) w_next = WR_HOLD;
      WR_HOLD:  w_next = DONE;
      DONE:     w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Strobe levels are decoded from the next state and registered, so pins never glitch.
  always_comb begin
    w_oe_n_nxt  = (w_next == RD) ? ASSERT_N : DEASSERT_N;
    w_we_n_nxt  = (w_next == WR) ? ASSERT_N : DEASSERT_N;
    w_dq_oe_nxt = (w_next == WR_SETUP) || (w_next == WR) || (w_next == WR_HOLD);
    Done        = (r_state == DONE);
    Busy        = (r_state != IDLE);
    Dbg_state   = r_state;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_wait  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_oe_n  <= DEASSERT_N;
      r_we_n  <= DEASSERT_N;
      r_en_n  <= DEASSERT_N;
      r_dq_oe <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_en_n  <= ASSERT_N;
      r_oe_n  <= w_oe_n_nxt;
      r_we_n  <= w_we_n_nxt;
      r_dq_oe <= w_dq_oe_nxt;
      r_err   <= (r_state == IDLE) && w_conflict;
      if (w_accept) begin
        r_addr  <= SRAM_AW'(Addr);
        r_wdata <= Wdata;
        r_wait  <= WS;
      end else if ((r_state == RD || r_state == WR) && !w_last_wait) begin
        r_wait <= r_wait - WAIT_CW'(1);
      end
      if (w_accept && Req_rd && w_is_io)    r_rdata <= w_sw_sync;
      else if (r_state == RD && w_last_wait) r_rdata <= Sram_dq;
    end
  end

  assign Sram_dq   = r_dq_oe ? r_wdata : 16'hzzzz;
  assign Sram_addr = r_addr;
  assign Sram_oe_n = r_oe_n;
  assign Sram_we_n = r_we_n;
  assign Sram_ce_n = r_en_n;
  assign Sram_ub_n = r_en_n;
  assign Sram_lb_n = r_en_n;
  assign Rdata     = r_rdata;
  assign Err       = r_err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: three instances (1, 2 and 15 wait states), each with an SRAM model,
// driven by directed and random transactions and scored against a transaction-level reference.
module tb_mem_access_ctrl;
  import mem_ctrl_pkg::*;

  localparam int N  = 3;
  localparam int AW = 20;
  localparam int WS_TAB [N] = '{1, 2, 15};

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n     [N];
  logic          req_rd    [N];
  logic          req_wr    [N];
  logic [15:0]   addr      [N];
  logic [15:0]   wdata     [N];
  logic [15:0]   switches  [N];
  logic [15:0]   rdata     [N];
  logic [15:0]   hex       [N];
  logic          done      [N];
  logic          busy      [N];
  logic          err       [N];
  logic [AW-1:0] sram_addr [N];
  logic          ce_n      [N];
  logic          oe_n      [N];
  logic          we_n      [N];
  logic          ub_n      [N];
  logic          lb_n      [N];
  state_t        dbg       [N];
  logic [15:0]   dq_obs    [N];
  logic [15:0]   rd_word   [N];

  logic [15:0] sram_mem [N][4096];
  bit          mem_ready = 1'b0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    wire [15:0] dq;
    assign dq = (!ce_n[g] && !oe_n[g] && we_n[g]) ? rd_word[g] : 16'hzzzz;
    assign dq_obs[g] = dq;

    mem_access_ctrl #(.WAIT_STATES(WS_TAB[g]), .IO_ADDR(16'hFFFF), .SRAM_AW(AW)) u_dut (
      .Clk      (clk),
      .Reset_n  (rst_n[g]),
      .Req_rd   (req_rd[g]),
      .Req_wr   (req_wr[g]),
      .Addr     (addr[g]),
      .Wdata    (wdata[g]),
      .Rdata    (rdata[g]),
      .Done     (done[g]),
      .Busy     (busy[g]),
      .Err      (err[g]),
      .Switches (switches[g]),
      .Hex_out  (hex[g]),
      .Sram_addr(sram_addr[g]),
      .Sram_dq  (dq),
      .Sram_ce_n(ce_n[g]),
      .Sram_oe_n(oe_n[g]),
      .Sram_we_n(we_n[g]),
      .Sram_ub_n(ub_n[g]),
      .Sram_lb_n(lb_n[g]),
      .Dbg_state(dbg[g])
    );
  end

  // asynchronous SRAM model: stores the bus while WE_n is low, drives it while OE_n is low
  always @(negedge clk) begin
    if (!mem_ready) begin
      for (int k = 0; k < N; k++)
        for (int i = 0; i < 4096; i++) sram_mem[k][i] = 16'h0000;
      mem_ready = 1'b1;
    end
    for (int k = 0; k < N; k++) begin
      if (rst_n[k] && !ce_n[k] && !we_n[k]) sram_mem[k][sram_addr[k][11:0]] = dq_obs[k];
      rd_word[k] = sram_mem[k][sram_addr[k][11:0]];
    end
  end

  // scoreboard / reference
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_q [$];
  logic [15:0] ref_mem [int];
  logic [15:0] exp_rd  [N];
  logic [15:0] exp_hex [N];
  logic [15:0] pool    [8];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic string tg(input int k, input string s);
    return $sformatf("ws%0d_%s", WS_TAB[k], s);
  endfunction

  // driver tasks
  task automatic do_reset(input int k);
    req_rd[k] = 1'b0;
    req_wr[k] = 1'b0;
    @(negedge clk);
    rst_n[k] = 1'b0;
    #1;
    check_val(tg(k, "rst_rdata"), 32'(rdata[k]), 32'h0);
    check_val(tg(k, "rst_hex"), 32'(hex[k]), 32'h0);
    check_val(tg(k, "rst_done"), 32'(done[k]), 32'h0);
    check_val(tg(k, "rst_busy"), 32'(busy[k]), 32'h0);
    check_val(tg(k, "rst_err"), 32'(err[k]), 32'h0);
    check_val(tg(k, "rst_addr"), 32'(sram_addr[k]), 32'h0);
    check_val(tg(k, "rst_strobes"), {27'd0, ce_n[k], oe_n[k], we_n[k], ub_n[k], lb_n[k]}, 32'h1F);
    @(negedge clk);
    @(negedge clk);
    rst_n[k] = 1'b1;
    @(negedge clk);
    check_val(tg(k, "run_strobes"), {27'd0, ce_n[k], oe_n[k], we_n[k], ub_n[k], lb_n[k]}, 32'h0C);
    check_val(tg(k, "run_busy"), 32'(busy[k]), 32'h0);
    exp_rd[k]  = 16'h0;
    exp_hex[k] = 16'h0;
  endtask

  task automatic set_sw(input int k, input logic [15:0] v);
    switches[k] = v;
    repeat (3) @(negedge clk);
  endtask

  task automatic txn(input int k, input bit rd, input bit wr, input logic [15:0] a,
                     input logic [15:0] wd, input int inject);
    int ws, lat, oe_cnt, we_cnt, drv_cnt, both_low, addr_bad, idle_gap, err_cnt, extra_done;
    int key, exp_lat;
    bit is_io;
    logic [15:0] got_rd, exp_val;
    ws = WS_TAB[k];
    is_io = (a == 16'hFFFF);
    key = k * 65536 + int'(a);
    if (rd) begin
      if (is_io) exp_q.push_back(switches[k]);
      else       exp_q.push_back(ref_mem.exists(key) ? ref_mem[key] : 16'h0000);
    end else if (is_io) begin
      exp_hex[k] = wd;
    end else begin
      ref_mem[key] = wd;
    end
    exp_lat = is_io ? 1 : (rd ? ws + 1 : ws + 3);
    lat = 0; oe_cnt = 0; we_cnt = 0; drv_cnt = 0; both_low = 0;
    addr_bad = 0; idle_gap = 0; err_cnt = 0; extra_done = 0;
    got_rd = 16'h0;
    @(negedge clk);
    req_rd[k] = rd;
    req_wr[k] = wr;
    addr[k]   = a;
    wdata[k]  = wd;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (inject != 0 && c == inject) req_rd[k] = 1'b1;
      if (!oe_n[k]) oe_cnt++;
      if (!we_n[k]) we_cnt++;
      if (!oe_n[k] && !we_n[k]) both_low++;
      if (oe_n[k] && dq_obs[k] === wd) drv_cnt++;
      if ((!oe_n[k] || !we_n[k]) && sram_addr[k] !== {4'h0, a}) addr_bad++;
      if (!busy[k]) idle_gap++;
      if (err[k]) err_cnt++;
      if (done[k]) begin
        lat = c;
        got_rd = rdata[k];
        break;
      end
    end
    req_rd[k] = 1'b0;
    req_wr[k] = 1'b0;
    check_val(tg(k, "latency"), 32'(lat), 32'(exp_lat));
    check_val(tg(k, "oe_width"), 32'(oe_cnt), 32'((rd && !is_io) ? ws : 0));
    check_val(tg(k, "we_width"), 32'(we_cnt), 32'((wr && !is_io) ? ws : 0));
    check_val(tg(k, "dq_drive"), 32'(drv_cnt), 32'((wr && !is_io) ? ws + 2 : 0));
    check_val(tg(k, "oe_we_overlap"), 32'(both_low), 32'h0);
    check_val(tg(k, "sram_addr"), 32'(addr_bad), 32'h0);
    check_val(tg(k, "busy_gap"), 32'(idle_gap), 32'h0);
    check_val(tg(k, "err_spurious"), 32'(err_cnt), 32'h0);
    if (rd) begin
      exp_val = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0;
      exp_rd[k] = exp_val;
      check_val(tg(k, "rdata"), 32'(got_rd), 32'(exp_val));
    end else begin
      check_val(tg(k, "rdata_kept"), 32'(got_rd), 32'(exp_rd[k]));
    end
    check_val(tg(k, "hex"), 32'(hex[k]), 32'(exp_hex[k]));
    repeat (2) begin
      @(negedge clk);
      if (done[k]) extra_done++;
    end
    check_val(tg(k, "single_done"), 32'(extra_done), 32'h0);
    check_val(tg(k, "rdata_held"), 32'(rdata[k]), 32'(exp_rd[k]));
  endtask

  task automatic conflict(input int k);
    @(negedge clk);
    req_rd[k] = 1'b1;
    req_wr[k] = 1'b1;
    addr[k]   = 16'(($urandom_range(0, 16'h0EFF)));
    @(negedge clk);
    req_rd[k] = 1'b0;
    req_wr[k] = 1'b0;
    check_val(tg(k, "err_pulse"), 32'(err[k]), 32'h1);
    check_val(tg(k, "err_busy"), 32'(busy[k]), 32'h0);
    check_val(tg(k, "err_strobes"), {30'd0, oe_n[k], we_n[k]}, 32'h3);
    @(negedge clk);
    check_val(tg(k, "err_end"), 32'(err[k]), 32'h0);
    check_val(tg(k, "err_done"), 32'(done[k]), 32'h0);
    check_val(tg(k, "err_rdata"), 32'(rdata[k]), 32'(exp_rd[k]));
  endtask

  task automatic reset_mid_write(input int k);
    logic [15:0] wd;
    int dones;
    wd = 16'hA11C;
    dones = 0;
    @(negedge clk);
    req_wr[k] = 1'b1;
    addr[k]   = 16'h0F80;
    wdata[k]  = wd;
    @(negedge clk);
    @(negedge clk);
    check_val(tg(k, "mid_we_low"), 32'(we_n[k]), 32'h0);
    #2;
    rst_n[k] = 1'b0;
    #1;
    check_val(tg(k, "abort_strobes"), {27'd0, ce_n[k], oe_n[k], we_n[k], ub_n[k], lb_n[k]}, 32'h1F);
    check_val(tg(k, "abort_dq"), 32'(dq_obs[k] !== wd), 32'h1);
    check_val(tg(k, "abort_busy"), 32'(busy[k]), 32'h0);
    check_val(tg(k, "abort_hex"), 32'(hex[k]), 32'h0);
    check_val(tg(k, "abort_rdata"), 32'(rdata[k]), 32'h0);
    req_wr[k] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done[k]) dones++;
    end
    rst_n[k] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done[k]) dones++;
    end
    check_val(tg(k, "abort_no_done"), 32'(dones), 32'h0);
    exp_rd[k]  = 16'h0;
    exp_hex[k] = 16'h0;
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      rst_n[k] = 1'b1; req_rd[k] = 1'b0; req_wr[k] = 1'b0;
      addr[k] = '0; wdata[k] = '0; switches[k] = '0;
      exp_rd[k] = '0; exp_hex[k] = '0;
    end
    #1;
    for (int k = 0; k < N; k++) rst_n[k] = 1'b0;

    for (int k = 0; k < N; k++) begin
      do_reset(k);
      for (int i = 0; i < 8; i++) pool[i] = 16'($urandom_range(0, 16'h0EFF));
      txn(k, 1, 0, 16'h0123, 16'h5A5A, 0);
      txn(k, 0, 1, 16'h0123, 16'hBEEF, 0);
      txn(k, 1, 0, 16'h0123, 16'h7777, 0);
      txn(k, 0, 1, 16'h0040, 16'h1234, 0);
      txn(k, 1, 0, 16'h0040, 16'h1111, 0);
      set_sw(k, 16'h00A5);
      txn(k, 1, 0, 16'hFFFF, 16'h2222, 0);
      txn(k, 0, 1, 16'hFFFF, 16'hC0DE, 0);
      conflict(k);
      txn(k, 0, 1, 16'h0200, 16'h3C3C, 2);
      txn(k, 1, 0, 16'h0200, 16'h4444, 0);
      for (int i = 0; i < 14; i++) begin
        int kind;
        logic [15:0] wd, a;
        kind = $urandom_range(0, 9);
        wd   = 16'($urandom_range(1, 16'hFFFE));
        a    = pool[$urandom_range(0, 7)];
        if (kind <= 1) begin
          set_sw(k, 16'($urandom));
          txn(k, 1, 0, 16'hFFFF, wd, 0);
        end else if (kind == 2) begin
          txn(k, 0, 1, 16'hFFFF, wd, 0);
        end else if (kind <= 5) begin
          txn(k, 0, 1, a, wd, 0);
        end else begin
          txn(k, 1, 0, a, wd, 0);
        end
      end
      txn(k, 0, 1, 16'hFFFF, 16'h0F0F, 0);
      reset_mid_write(k);
      txn(k, 0, 1, 16'hFFFF, 16'h5EED, 0);
      txn(k, 1, 0, 16'h0040, 16'h6666, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
